// File: rtl/dnn_sample_sequencer.sv
// Host-to-DNN sample feeder: double-buffers whole samples, slices them into per-clock
// a_in/y_in chunks locked to a mirrored block-cycle counter, and scores delayed predictions.
module dnn_sample_sequencer #(
  parameter int width    = 16,
  parameter int width_in = 8,
  parameter int N0       = 16,
  parameter int NL       = 4,
  parameter int ZA       = 4,
  parameter int ZY       = 1,
  parameter int CPC      = 6,
  parameter int RES_LAT  = 3,
  parameter int CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [N0*width_in-1:0]   s_act,
  input  logic [NL-1:0]            s_label,
  input  logic [width-1:0]         s_eta,
  output logic [ZA*width_in-1:0]   a_in,
  output logic [ZY-1:0]            y_in,
  output logic [width-1:0]         eta_in,
  input  logic [NL-1:0]            a_out_alln,
  output logic [$clog2(CPC)-1:0]   cycle_index,
  output logic                     res_valid,
  output logic                     res_correct,
  output logic [CNT_W-1:0]         sample_count,
  output logic [CNT_W-1:0]         correct_count
);

  localparam int IDX_W   = $clog2(CPC);
  localparam int ACT_W   = N0 * width_in;
  localparam int CHUNK_A = ZA * width_in;

  typedef struct packed {
    logic              valid;
    logic [ACT_W-1:0]  act;
    logic [NL-1:0]     label;
    logic [width-1:0]  eta;
  } sample_t;

  // Host stream: s_valid/s_ready handshake; a sample transfers on any clock where both are
  // high, and the host must hold s_act/s_label/s_eta stable while s_valid waits for s_ready.

  sample_t                      pend_q, pend_d;
  sample_t                      act_q, act_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [RES_LAT-1:0]           pv_q, pv_d;
  logic [RES_LAT-1:0][NL-1:0]   pl_q, pl_d;
  logic [CHUNK_A-1:0]           a_q, a_d;
  logic [ZY-1:0]                y_q, y_d;
  logic [width-1:0]             eta_q, eta_d;
  logic [CNT_W-1:0]             scnt_q, scnt_d;
  logic [CNT_W-1:0]             ccnt_q, ccnt_d;

  logic block_end;
  logic promote;
  logic load;

  assign block_end   = (idx_q == IDX_W'(CPC - 1));
  assign promote     = block_end && run && pend_q.valid;
  assign s_ready     = !pend_q.valid || (block_end && run);
  assign load        = s_valid && s_ready;
  assign res_valid   = block_end && pv_q[RES_LAT-1];
  assign res_correct = res_valid && (a_out_alln == pl_q[RES_LAT-1]);

  always_comb begin
    idx_d  = block_end ? '0 : idx_q + IDX_W'(1);
    pend_d = pend_q;
    act_d  = act_q;
    pv_d   = pv_q;
    pl_d   = pl_q;
    scnt_d = scnt_q;
    ccnt_d = ccnt_q;

    if (promote) pend_d.valid = 1'b0;
    if (load)    pend_d = {1'b1, s_act, s_label, s_eta};

    // The block just fed enters the label pipe as the next one is promoted (or bubbled).
    if (block_end) begin
      act_d = promote ? pend_q : '0;
      pv_d  = {pv_q[RES_LAT-2:0], act_q.valid};
      pl_d  = {pl_q[RES_LAT-2:0], act_q.label};
    end

    // Outputs are registered from the upcoming active block and index.
    a_d   = '0;
    y_d   = '0;
    eta_d = act_d.valid ? act_d.eta : '0;
    for (int k = 0; k < CPC - 2; k++) begin
      if (idx_d == IDX_W'(k)) begin
        a_d = act_d.act[k*CHUNK_A +: CHUNK_A];
        y_d = act_d.label[k*ZY +: ZY];
      end
    end

    if (res_valid && !(&scnt_q))   scnt_d = scnt_q + CNT_W'(1);
    if (res_correct && !(&ccnt_q)) ccnt_d = ccnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      pend_q <= '0;
      act_q  <= '0;
      pv_q   <= '0;
      pl_q   <= '0;
      a_q    <= '0;
      y_q    <= '0;
      eta_q  <= '0;
      scnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      idx_q  <= idx_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      pv_q   <= pv_d;
      pl_q   <= pl_d;
      a_q    <= a_d;
      y_q    <= y_d;
      eta_q  <= eta_d;
      scnt_q <= scnt_d;
      ccnt_q <= ccnt_d;
    end
  end

  assign a_in          = a_q;
  assign y_in          = y_q;
  assign eta_in        = eta_q;
  assign cycle_index   = idx_q;
  assign sample_count  = scnt_q;
  assign correct_count = ccnt_q;

endmodule

// File: tb/tb_dnn_sample_sequencer.sv
// Directed bench for dnn_sample_sequencer: queued expectations, decoupled feed/result monitors.
module tb_dnn_sample_sequencer;

  localparam logic [3:0] A_TIE = 4'b0100;

  logic         clk = 1'b0;
  logic         reset;
  logic         run;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_act;
  logic [3:0]   s_label;
  logic [15:0]  s_eta;
  logic [31:0]  a_in;
  logic [0:0]   y_in;
  logic [15:0]  eta_in;
  logic [3:0]   a_out_alln;
  logic [2:0]   cycle_index;
  logic         res_valid;
  logic         res_correct;
  logic [31:0]  sample_count;
  logic [31:0]  correct_count;

  dnn_sample_sequencer dut (
    .clk(clk), .reset(reset), .run(run),
    .s_valid(s_valid), .s_ready(s_ready), .s_act(s_act), .s_label(s_label), .s_eta(s_eta),
    .a_in(a_in), .y_in(y_in), .eta_in(eta_in), .a_out_alln(a_out_alln),
    .cycle_index(cycle_index), .res_valid(res_valid), .res_correct(res_correct),
    .sample_count(sample_count), .correct_count(correct_count)
  );

  // ---------------- clock / reset-relative cycle count ----------------
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [127:0] act;
    logic [3:0]   label;
    logic [15:0]  eta;
  } feed_t;

  feed_t      exp_feed[$];
  logic [0:0] exp_q[$];
  int         feed_blk_q[$];
  int         feed_log[$];
  feed_t      cur;
  logic       cur_act;
  int         n_tests;
  int         n_fail;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic flush();
    exp_feed.delete();
    exp_q.delete();
    feed_blk_q.delete();
    cur_act = 1'b0;
  endtask

  // Feed and result monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      int k;
      k = cyc % 6;
      chk("cycle_index", cycle_index, k);
      if (k == 0) begin
        cur_act = 1'b0;
        if (eta_in != 0) begin
          if (exp_feed.size() == 0) begin
            chk("unexpected_feed", 1, 0);
          end else begin
            cur = exp_feed.pop_front();
            cur_act = 1'b1;
            feed_blk_q.push_back(cyc / 6);
            feed_log.push_back(cyc / 6);
          end
        end
      end
      if (cur_act) begin
        chk("feed_eta", eta_in, cur.eta);
        chk("feed_a_in", a_in, (k < 4) ? {96'd0, cur.act[k*32 +: 32]} : 128'd0);
        chk("feed_y_in", y_in, (k < 4) ? {127'd0, cur.label[k]} : 128'd0);
      end else begin
        chk("bubble_a_in", a_in, 0);
        chk("bubble_y_in", y_in, 0);
        chk("bubble_eta", eta_in, 0);
      end
      if (res_valid) begin
        chk("res_phase", k, 5);
        if (exp_q.size() == 0) begin
          chk("unexpected_res_valid", 1, 0);
        end else begin
          chk("res_correct", res_correct, exp_q.pop_front());
          if (feed_blk_q.size() != 0) chk("res_latency", cyc / 6, feed_blk_q.pop_front() + 3);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [127:0] make_act(input int base);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'(base + i);
    return v;
  endfunction

  // Called on a falling edge; returns on the falling edge after the handshake.
  task automatic send(input logic [127:0] act, input logic [3:0] label, input logic [15:0] eta,
                      output int acc_idx);
    feed_t f;
    int guard;
    s_valid = 1'b1;
    s_act   = act;
    s_label = label;
    s_eta   = eta;
    guard   = 0;
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    acc_idx = cyc % 6;
    if (!s_ready) begin
      chk("send_timeout", 1, 0);
    end else begin
      f.act = act; f.label = label; f.eta = eta;
      exp_feed.push_back(f);
      exp_q.push_back(label == A_TIE);
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    flush();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_blocks(input int n);
    repeat (n * 6) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] a_tab [6] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D, 32'h0, 32'h0};
  logic [0:0]  y_tab [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [3:0]  lab3  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    int acc;
    int s0;
    int rb;
    n_tests = 0; n_fail = 0; cur_act = 1'b0;
    reset = 1'b1; run = 1'b1; s_valid = 1'b0;
    s_act = '0; s_label = '0; s_eta = '0; a_out_alln = A_TIE;
    #23;
    chk("rst_a_in", a_in, 0);
    chk("rst_eta", eta_in, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_idx", cycle_index, 0);
    chk("rst_sample_count", sample_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // Idle: bubbles only, always ready, no results.
    repeat (24) begin
      @(negedge clk);
      chk("idle_s_ready", s_ready, 1);
    end
    chk("idle_sample_count", sample_count, 0);
    chk("idle_correct_count", correct_count, 0);

    // Single sample with hand-computed chunks.
    send(make_act(1), 4'b0100, 16'h0100, acc);
    s_valid = 1'b0;
    while (cyc % 6 != 0) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      chk("single_a_in", a_in, a_tab[k]);
      chk("single_y_in", y_in, y_tab[k]);
      chk("single_eta", eta_in, 16'h0100);
      @(negedge clk);
    end
    wait_blocks(4);
    chk("single_sample_count", sample_count, 1);
    chk("single_correct_count", correct_count, 1);

    // Back-to-back with s_valid held: later handshakes only at index 5, no bubbles.
    s0 = feed_log.size();
    for (int i = 0; i < 4; i++) begin
      send(make_act(16 * i + 32), lab3[i], 16'(16'h0200 + i), acc);
      if (i > 0) chk("b2b_ready_phase", acc, 5);
    end
    s_valid = 1'b0;
    wait_blocks(8);
    chk("b2b_feeds", feed_log.size() - s0, 4);
    for (int i = 0; i < 3; i++)
      if (feed_log.size() > s0 + i + 1)
        chk("b2b_no_bubble", feed_log[s0 + i + 1], feed_log[s0 + i] + 1);
    chk("b2b_sample_count", sample_count, 5);
    chk("b2b_correct_count", correct_count, 2);

    // Scoring from a clean start: labels 0100 then 0001 against a fixed 0100 prediction.
    pulse_reset();
    chk("score_rst_count", sample_count, 0);
    send(make_act(100), 4'b0100, 16'h0011, acc);
    send(make_act(120), 4'b0001, 16'h0022, acc);
    s_valid = 1'b0;
    wait_blocks(8);
    chk("score_sample_count", sample_count, 2);
    chk("score_correct_count", correct_count, 1);

    // run=0 holds a pending sample through two bubble blocks.
    run = 1'b0;
    send(make_act(200), 4'b0100, 16'h0033, acc);
    s_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("hold_s_ready", s_ready, 0);
    end
    while (cyc % 6 != 2) @(negedge clk);
    run = 1'b1;
    rb = cyc / 6;
    wait_blocks(6);
    chk("resume_feed_block", feed_log[feed_log.size() - 1], rb + 1);
    chk("resume_sample_count", sample_count, 3);

    // Asynchronous reset mid-block with two samples in flight.
    send(make_act(64), 4'b0100, 16'h0044, acc);
    send(make_act(80), 4'b0001, 16'h0055, acc);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    flush();
    #1;
    chk("async_a_in", a_in, 0);
    chk("async_y_in", y_in, 0);
    chk("async_eta", eta_in, 0);
    chk("async_idx", cycle_index, 0);
    chk("async_res_valid", res_valid, 0);
    chk("async_s_ready", s_ready, 1);
    chk("async_sample_count", sample_count, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_blocks(6);
    chk("post_rst_sample_count", sample_count, 0);
    chk("post_rst_correct_count", correct_count, 0);
    chk("feed_queue_empty", exp_feed.size(), 0);
    chk("res_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dnn_sample_sequencer.md
Name: dnn_sample_sequencer

Overview:
- Feeds training samples into the DNN top level and scores its predictions.
- Accepts whole samples (activations, one-hot label, eta) from a host over a valid/ready stream and double-buffers them.
- Slices each sample into per-clock a_in/y_in chunks, locked to a block-cycle counter that mirrors the DNN's cycle counter; both reset together, so they stay aligned.
- Tracks in-flight labels and compares each against the DNN's one-hot a_out_alln, keeping running sample and correct counts.

Parameters:
- width, 16, bit width of eta
- width_in, 8, bits per input activation
- N0, 16, input-layer neurons
- NL, 4, output-layer neurons
- ZA, 4, activations per clock on a_in (z[0]/fo[0])
- ZY, 1, label bits per clock on y_in (z[L-2]/fi[L-2])
- CPC, 6, clocks per block cycle; must equal N0/ZA+2 and NL/ZY+2
- RES_LAT, 3, block cycles from a sample's feed block until its a_out_alln is sampled (equals L)
- CNT_W, 32, width of the statistics counters

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- run  in  1  1 = promote pending samples; 0 = insert bubbles
- s_valid  in  1  host sample valid
- s_ready  out  1  sequencer can accept a sample
- s_act  in  N0*width_in  sample activations; neuron 0 in the LSBs
- s_label  in  NL  one-hot ideal output
- s_eta  in  width  learning rate for this sample
- a_in  out  ZA*width_in  activation chunk to the DNN
- y_in  out  ZY  label chunk to the DNN
- eta_in  out  width  eta to the DNN
- a_out_alln  in  NL  DNN one-hot prediction
- cycle_index  out  clog2(CPC)  mirrored block-cycle counter
- res_valid  out  1  one-clock pulse when a result is scored
- res_correct  out  1  scored prediction matched its label
- sample_count  out  CNT_W  real samples scored
- correct_count  out  CNT_W  correct predictions

Behaviour:
- Reset (asynchronous, active-high):
  - cycle_index=0; pending and active buffers empty.
  - a_in, y_in, eta_in = 0; s_ready=1; res_valid=0; res_correct=0; counts=0.
  - Label pipeline cleared and all in-flight samples discarded; the same behaviour applies if reset is asserted mid-operation.
- Counter: cycle_index increments every clk and wraps CPC-1 -> 0.
- Pending buffer (one entry):
  - Loads on s_valid&s_ready.
  - s_ready = pending empty OR (cycle_index==CPC-1 AND run), i.e. a promotion that frees the slot this clock.
  - Load and promote in the same clock: the old entry moves to active and the new sample lands in pending. No loss, no duplication.
- Promotion at cycle_index==CPC-1:
  - If run=1 and pending is full, pending moves to active (valid=1) and pending empties.
  - Otherwise active becomes a bubble (valid=0) and any pending entry is retained.
- Drive, registered from active and cycle_index (chunk k appears on the outputs at cycle_index k):
  - For k in 0..CPC-3: a_in = act[k*ZA*width_in +: ZA*width_in]; y_in = label[k*ZY +: ZY].
  - For k = CPC-2 and CPC-1: a_in=0, y_in=0.
  - eta_in = active eta for the whole block; 0 for a bubble (no weight update).
- Label pipeline:
  - RES_LAT-deep shift register of {valid, label}, advanced at cycle_index==CPC-1, entering from the block being promoted.
  - At cycle_index==CPC-1, if the output stage valid=1:
    - res_valid pulses for one clock.
    - res_correct = (a_out_alln == label).
    - sample_count += 1; correct_count += res_correct.
  - Bubbles produce no pulse and no count change.
- Counters saturate at all-ones and do not wrap.
- run=0 mid-block: the current active block completes its drive unchanged; only later promotions are suppressed.

Test Plan:
- Reset then idle 4 blocks -> a_in=0, eta_in=0, s_ready=1, res_valid never asserted, counts=0.
- One sample, act bytes 0x01..0x10, label 4'b0100, eta 0x0100, run=1 -> next block: a_in = 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D at idx 0..3; y_in = 0,0,1,0; eta_in=0x0100.
- Back-to-back samples with s_valid held -> s_ready high only at idx 5 once pending is full; each block carries a new sample; no bubbles.
- Tie a_out_alln = 4'b0100 with labels 0100, 0001 fed in consecutive blocks -> res_valid RES_LAT blocks after each feed block; res_correct 1 then 0; sample_count=2, correct_count=1.
- run=0 with a pending sample for 2 blocks -> bubbles, eta_in=0, pending retained; run=1 -> the sample issues in the following block.
- Assert reset mid-block with 2 samples in flight -> all outputs 0 immediately (async); no res_valid afterwards for the discarded samples.
